vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Generates VGA raster timing from the high-speed PLL output clock. An internal divide-by-`PIX_DIV` produces a one-cycle pixel clock-enable. Horizontal and vertical counters advance on that enable and drive sync, data-enable, pixel coordinates and frame/line markers. It sits directly downstream of the PLL and feeds the pixel source and the video output stage. Defaults are 800x600@60 from the ~200 MHz PLL clock (40 MHz pixel rate).

## Interface
Parameters:
- `PIX_DIV`, 5: clkin cycles per pixel; legal range 1..16.
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 40: horizontal front porch, in pixels.
- `H_SYNC`, 128: hsync width, in pixels.
- `H_BP`, 88: horizontal back porch, in pixels.
- `V_ACTIVE`, 600: visible lines.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vsync width, in lines.
- `V_BP`, 23: vertical back porch, in lines.
- `H_POL`, 1: active level of hsync.
- `V_POL`, 1: active level of vsync.

Ports:
- `clkin` in 1: PLL output clock; the only clock.
- `rst` in 1: reset; synchronous, active-high.
- `pix_ce` out 1: pixel enable, high one clkin cycle in every `PIX_DIV`.
- `hsync` out 1: horizontal sync at polarity `H_POL`.
- `vsync` out 1: vertical sync at polarity `V_POL`.
- `de` out 1: high while the position is in the active area.
- `x` out 12: current horizontal count, 0..H_TOTAL-1.
- `y` out 12: current vertical count, 0..V_TOTAL-1.
- `line_start` out 1: high while x==0.
- `frame_start` out 1: high while x==0 and y==0.

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628).
  - Both totals must be ≤4095; elaboration fails otherwise.
- Divider counter `div` runs 0..PIX_DIV-1 and wraps.
  - `pix_ce` is registered; it is high in the cycle following the edge at which `div` reached PIX_DIV-1.
  - For PIX_DIV=1, `pix_ce` is continuously high after reset.
- Position (h,v) advances at every clkin edge where `pix_ce` is high:
  - h increments.
  - At h==H_TOTAL-1, h wraps to 0 and v increments.
  - At v==V_TOTAL-1 together with h wrap, v wraps to 0.
- All outputs are registered and change only at advancing edges; they are stable for the whole `pix_ce` window.
- Output decode for position (h,v):
  - `de` = (h<H_ACTIVE) && (v<V_ACTIVE).
  - hsync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (default 840..967).
  - vsync is active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (default 601..604).
  - vsync changes at the h-wrap edge, aligned with hsync timing.
  - x=h and y=v at all times; x and y are not masked by `de`.
- Arithmetic is unsigned 12-bit. Comparisons are made against elaboration-time constants, with no runtime division.

## Timing
- Reset values, held while `rst` is high:
  - div=0, `pix_ce`=0.
  - x=H_TOTAL-1 (1055), y=V_TOTAL-1 (627).
  - de=0, hsync=~H_POL, vsync=~V_POL.
  - line_start=0, frame_start=0.
- Sequence after reset release, with E1 the first edge sampling rst=0:
  - `pix_ce` is high after edges E(n·PIX_DIV), n≥1.
  - Position advances at E(n·PIX_DIV+1).
  - The first advance moves the position to (0,0): frame_start, line_start and de rise at E(PIX_DIV+1).
- frame_start and line_start are levels lasting exactly one pixel (PIX_DIV clkin cycles); they are not single-clkin pulses.
- Latency from position change to output is 0 pixels; the outputs are the position registers plus decode registers, updated on the same edge.
- `rst` asserted mid-line or mid-frame: at the next edge all outputs return to their reset values, with no partial-line completion.
- `rst` is always dominant over `pix_ce`.

## Test plan
- Reset release, defaults:
  - `pix_ce` pulses 1-of-5 cycles.
  - The first pulse occurs 5 cycles after release.
  - x/y go 1055/627 -> 0/0.
  - frame_start is high for exactly 5 clkin cycles.
- Full line, defaults:
  - de is high for 800 pixels (4000 clkin).
  - hsync is high for x=840..967 (128 pixels).
  - line period is 1056 pixels = 5280 clkin.
- Full frame, defaults:
  - vsync is high for y=601..604, i.e. 4 lines = 21120 clkin.
  - frame_start recurs every 663168 pixels = 3315840 clkin.
- PIX_DIV=1 with a small raster (H 4/1/2/1, V 3/1/1/1):
  - pix_ce is constant high.
  - x wraps 7->0; y wraps 5->0.
  - hsync is active at x=5,6.
- rst pulsed for 1 cycle at x=300, y=200:
  - Next cycle shows x=1055, y=627, de=0, both syncs inactive, pix_ce=0.
  - Restart timing matches scenario 1.
- Negative polarity (H_POL=0, V_POL=0):
  - Sync levels are inverted; reset levels are hsync=1, vsync=1.
  - de and counter timing are identical to the defaults.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides clkin into a pixel enable, counts h/v position, decodes sync/de/markers.
// Latency: outputs are registered and change on the edge where pix_ce is high (0 pixels after the position change).
// Backpressure: none; free-running source, rst returns every output to its reset value at the next edge.
module vga_timing_gen #(
    parameter int PIX_DIV  = 5,
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1
) (
    input  logic        clkin,
    input  logic        rst,
    output logic        pix_ce,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL_I > 4095 || V_TOTAL_I > 4095) begin : g_total_chk
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4095");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_div_chk
        $error("vga_timing_gen: PIX_DIV must be in 1..16");
    end

    localparam logic [3:0]  DIV_LAST = 4'(PIX_DIV - 1);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL_I - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL_I - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  div;
    logic [11:0] h_nxt;
    logic [11:0] v_nxt;
    logic        hs_act;
    logic        vs_act;

    // Next position; only used on edges where pix_ce is high.
    always_comb begin
        h_nxt = x + 12'd1;
        v_nxt = y;
        if (x == H_LAST) begin
            h_nxt = 12'd0;
            v_nxt = (y == V_LAST) ? 12'd0 : y + 12'd1;
        end
        hs_act = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vs_act = (v_nxt >= VS_START) && (v_nxt < VS_END);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            div    <= 4'd0;
            pix_ce <= 1'b0;
        end else begin
            div    <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
            pix_ce <= (div == DIV_LAST);
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            x           <= H_LAST;
            y           <= V_LAST;
            de          <= 1'b0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            x           <= h_nxt;
            y           <= v_nxt;
            de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            hsync       <= H_POL ? hs_act : ~hs_act;
            vsync       <= V_POL ? vs_act : ~vs_act;
            line_start  <= (h_nxt == 12'd0);
            frame_start <= (h_nxt == 12'd0) && (v_nxt == 12'd0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default raster (reset, first line, mid-line reset), small PIX_DIV=1 raster, small inverted-polarity raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b1, rst_s = 1'b1, rst_n2 = 1'b1;

    logic        ce_d, hs_d, vs_d, de_d, ls_d, fs_d;
    logic [11:0] x_d, y_d;
    logic        ce_s, hs_s, vs_s, de_s, ls_s, fs_s;
    logic [11:0] x_s, y_s;
    logic        ce_n, hs_n, vs_n, de_n, ls_n, fs_n;
    logic [11:0] x_n, y_n;

    int tests = 0;
    int fails = 0;

    vga_timing_gen u_def (
        .clkin(clk), .rst(rst_d), .pix_ce(ce_d), .hsync(hs_d), .vsync(vs_d), .de(de_d),
        .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .clkin(clk), .rst(rst_s), .pix_ce(ce_s), .hsync(hs_s), .vsync(vs_s), .de(de_s),
        .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
    );

    vga_timing_gen #(
        .PIX_DIV(2), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b0), .V_POL(1'b0)
    ) u_neg (
        .clkin(clk), .rst(rst_n2), .pix_ce(ce_n), .hsync(hs_n), .vsync(vs_n), .de(de_n),
        .x(x_n), .y(y_n), .line_start(ls_n), .frame_start(fs_n)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int de_cnt, hs_cnt, fs_cnt, ce_cnt, hs_min, hs_max;
    int mh, mv;

    initial begin
        // ---------------- default raster: reset state ----------------
        tick(3);
        chk("rst_pix_ce", ce_d, 0);
        chk("rst_x", x_d, 1055);
        chk("rst_y", y_d, 627);
        chk("rst_de", de_d, 0);
        chk("rst_hsync", hs_d, 0);
        chk("rst_vsync", vs_d, 0);
        chk("rst_line_start", ls_d, 0);
        chk("rst_frame_start", fs_d, 0);

        // ---------------- release: first pulse and first advance ----------------
        rst_d = 1'b0;
        tick(4);
        chk("e4_pix_ce", ce_d, 0);
        chk("e4_x", x_d, 1055);
        tick(1);
        chk("e5_pix_ce", ce_d, 1);
        chk("e5_x", x_d, 1055);
        chk("e5_frame_start", fs_d, 0);
        tick(1);
        chk("e6_x", x_d, 0);
        chk("e6_y", y_d, 0);
        chk("e6_frame_start", fs_d, 1);
        chk("e6_line_start", ls_d, 1);
        chk("e6_de", de_d, 1);
        chk("e6_pix_ce", ce_d, 0);

        // ---------------- one full line ----------------
        de_cnt = 0; hs_cnt = 0; fs_cnt = 0; ce_cnt = 0; hs_min = 4096; hs_max = -1;
        for (int i = 0; i < 5280; i++) begin
            if (de_d) de_cnt++;
            if (fs_d) fs_cnt++;
            if (ce_d) ce_cnt++;
            if (hs_d) begin
                hs_cnt++;
                if (int'(x_d) < hs_min) hs_min = int'(x_d);
                if (int'(x_d) > hs_max) hs_max = int'(x_d);
            end
            tick(1);
        end
        chk("line_de_clks", de_cnt, 4000);
        chk("line_hsync_clks", hs_cnt, 640);
        chk("line_hsync_first_x", hs_min, 840);
        chk("line_hsync_last_x", hs_max, 967);
        chk("line_frame_start_clks", fs_cnt, 5);
        chk("line_pix_ce_count", ce_cnt, 1056);
        chk("line2_x", x_d, 0);
        chk("line2_y", y_d, 1);
        chk("line2_line_start", ls_d, 1);
        chk("line2_frame_start", fs_d, 0);
        chk("line2_vsync", vs_d, 0);

        // ---------------- mid-line reset at x=300 ----------------
        tick(1500);
        chk("pre_rst_x", x_d, 300);
        chk("pre_rst_y", y_d, 1);
        rst_d = 1'b1;
        tick(1);
        chk("mid_rst_x", x_d, 1055);
        chk("mid_rst_y", y_d, 627);
        chk("mid_rst_de", de_d, 0);
        chk("mid_rst_hsync", hs_d, 0);
        chk("mid_rst_vsync", vs_d, 0);
        chk("mid_rst_pix_ce", ce_d, 0);
        rst_d = 1'b0;
        tick(5);
        chk("restart_e5_pix_ce", ce_d, 1);
        chk("restart_e5_x", x_d, 1055);
        tick(1);
        chk("restart_e6_x", x_d, 0);
        chk("restart_e6_y", y_d, 0);
        chk("restart_e6_frame_start", fs_d, 1);

        // ---------------- PIX_DIV=1 small raster ----------------
        chk("small_rst_x", x_s, 7);
        chk("small_rst_y", y_s, 5);
        chk("small_rst_pix_ce", ce_s, 0);
        rst_s = 1'b0;
        tick(1);
        chk("small_e1_pix_ce", ce_s, 1);
        chk("small_e1_x", x_s, 7);
        tick(1);
        mh = 0; mv = 0;
        for (int i = 0; i < 50; i++) begin
            chk("small_pix_ce", ce_s, 1);
            chk("small_x", x_s, mh);
            chk("small_y", y_s, mv);
            chk("small_de", de_s, int'(mh < 4 && mv < 3));
            chk("small_hsync", hs_s, int'(mh == 5 || mh == 6));
            chk("small_vsync", vs_s, int'(mv == 4));
            chk("small_line_start", ls_s, int'(mh == 0));
            chk("small_frame_start", fs_s, int'(mh == 0 && mv == 0));
            if (mh == 7) begin
                mh = 0;
                mv = (mv == 5) ? 0 : mv + 1;
            end else begin
                mh++;
            end
            tick(1);
        end

        // ---------------- inverted polarity, PIX_DIV=2 small raster ----------------
        chk("neg_rst_hsync", hs_n, 1);
        chk("neg_rst_vsync", vs_n, 1);
        chk("neg_rst_de", de_n, 0);
        rst_n2 = 1'b0;
        tick(1);
        chk("neg_e1_pix_ce", ce_n, 0);
        tick(1);
        chk("neg_e2_pix_ce", ce_n, 1);
        chk("neg_e2_x", x_n, 7);
        tick(1);
        mh = 0; mv = 0;
        for (int i = 0; i < 100; i++) begin
            chk("neg_pix_ce", ce_n, i % 2);
            chk("neg_x", x_n, mh);
            chk("neg_y", y_n, mv);
            chk("neg_de", de_n, int'(mh < 4 && mv < 3));
            chk("neg_hsync", hs_n, int'(!(mh == 5 || mh == 6)));
            chk("neg_vsync", vs_n, int'(mv != 4));
            chk("neg_frame_start", fs_n, int'(mh == 0 && mv == 0));
            if (i % 2 == 1) begin
                if (mh == 7) begin
                    mh = 0;
                    mv = (mv == 5) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
            end
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
